// File: rtl/cuenta_regresiva_pkg.sv
// -----------------------------------------------------------------------------
// cuenta_pkg: shared types and constants for the mm:ss countdown timer.
//   state_e   : controller states (IDLE, RUN, PAUSE, DONE)
//   TIME_W    : width of a minutes/seconds field
//   MAX_SEG   : largest seconds value
//   MAX_MIN   : largest minutes value
//   sat_time(): clamps a raw preset field to a given maximum
// -----------------------------------------------------------------------------
package cuenta_pkg;

   localparam int unsigned TIME_W  = 6;
   localparam int unsigned MAX_SEG = 59;
   localparam int unsigned MAX_MIN = 59;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Presets above the limit clamp to the limit rather than wrapping.
   function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] v,
                                                  input int unsigned        lim);
      return (v > TIME_W'(lim)) ? TIME_W'(lim) : v;
   endfunction

endpackage

// File: rtl/cuenta_regresiva_if.sv
// -----------------------------------------------------------------------------
// cuenta_regresiva_if: control/display bundle between the time-setting stage,
// the countdown timer and the 7-seg/LED stage.
//   setTime, setSeg, setMin, start_stop : master -> slave (controls/presets)
//   seg, min, running, alarm, tick      : slave -> master (display/status)
// -----------------------------------------------------------------------------
interface cuenta_regresiva_if;
   import cuenta_pkg::*;

   logic              setTime;
   logic [TIME_W-1:0] setSeg;
   logic [TIME_W-1:0] setMin;
   logic              start_stop;
   logic [TIME_W-1:0] seg;
   logic [TIME_W-1:0] min;
   logic              running;
   logic              alarm;
   logic              tick;

   modport master (
      output setTime, setSeg, setMin, start_stop,
      input  seg, min, running, alarm, tick
   );

   modport slave (
      input  setTime, setSeg, setMin, start_stop,
      output seg, min, running, alarm, tick
   );

endinterface

// File: rtl/cuenta_regresiva_divisor_tick.sv
// -----------------------------------------------------------------------------
// divisor_tick: one-second prescaler for the countdown timer.
//   clk, rst  : clock, synchronous active-high reset
//   en_i      : advance the prescaler this cycle
//   clr_i     : return the prescaler to zero (wins over en_i)
//   tick_c_o  : combinational strobe, high while enabled at count CLK_HZ-1
// -----------------------------------------------------------------------------
module divisor_tick #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_c_o
);

   localparam int unsigned     CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_c_o = en_i && !clr_i && (cnt_q == TERM);

   // Wrap at TERM; hold when disabled so a pause resumes mid-second.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cuenta_regresiva.sv
// -----------------------------------------------------------------------------
// cuenta_regresiva: mm:ss countdown timer with alarm window.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : cuenta_regresiva_if.slave
//          in : setTime (edit mode, dominant), setSeg/setMin (presets),
//               start_stop (start/pause/resume/acknowledge pulse)
//          out: seg/min (current time), running (RUN only),
//               alarm (end-of-count window), tick (1 Hz strobe in RUN)
// Parameters: CLK_HZ (cycles per second), ALARM_SEC (alarm window length).
// Build option: define CUENTA_BLINK_EN to make the alarm toggle every half
// second during its window instead of staying high.
// -----------------------------------------------------------------------------
module cuenta_regresiva
   import cuenta_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned ALARM_SEC = 5
) (
   input  logic               clk,
   input  logic               rst,
   cuenta_regresiva_if.slave  bus
);

   localparam int unsigned ALARM_CYC = ALARM_SEC * CLK_HZ;
   localparam int unsigned ALM_W     = $clog2(ALARM_CYC + 1);

`ifdef CUENTA_BLINK_EN
   localparam int unsigned HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
   localparam int unsigned BL_W = (HALF > 1) ? $clog2(HALF) : 1;
   logic [BL_W-1:0] blk_q, blk_d;
`endif

   state_e            state_q, state_d;
   logic [TIME_W-1:0] seg_q, seg_d;
   logic [TIME_W-1:0] min_q, min_d;
   logic              running_q, running_d;
   logic              alarm_q, alarm_d;
   logic              tick_q;
   logic [ALM_W-1:0]  alm_tmr_q, alm_tmr_d;

   logic              tick_c;
   logic              presc_en_c;
   logic              presc_clr_c;
   logic [TIME_W-1:0] pre_seg_c;
   logic [TIME_W-1:0] pre_min_c;

   // Prescaler only advances in RUN; it is parked at zero while idle/editing.
   assign presc_en_c  = (state_q == RUN) && !bus.setTime;
   assign presc_clr_c = bus.setTime || (state_q == IDLE);

   divisor_tick #(.CLK_HZ(CLK_HZ)) u_divisor (
      .clk      (clk),
      .rst      (rst),
      .en_i     (presc_en_c),
      .clr_i    (presc_clr_c),
      .tick_c_o (tick_c)
   );

   assign pre_seg_c = sat_time(bus.setSeg, MAX_SEG);
   assign pre_min_c = sat_time(bus.setMin, MAX_MIN);

   // Next-state, time and alarm logic.
   always_comb begin
      state_d   = state_q;
      seg_d     = seg_q;
      min_d     = min_q;
      alarm_d   = 1'b0;
      alm_tmr_d = alm_tmr_q;
`ifdef CUENTA_BLINK_EN
      blk_d     = blk_q;
`endif

      if (bus.setTime) begin
         state_d   = IDLE;
         seg_d     = pre_seg_c;
         min_d     = pre_min_c;
         alm_tmr_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_stop && ((seg_q != '0) || (min_q != '0))) begin
                  state_d = RUN;
               end else begin
                  seg_d = pre_seg_c;
                  min_d = pre_min_c;
               end
            end

            RUN: begin
               if (tick_c) begin
                  if (seg_q == '0) begin
                     seg_d = TIME_W'(MAX_SEG);
                     min_d = min_q - TIME_W'(1);
                  end else begin
                     seg_d = seg_q - TIME_W'(1);
                  end
               end
               // Reaching 00:00 outranks a simultaneous pause request.
               if (tick_c && (min_q == '0) && (seg_q == TIME_W'(1))) begin
                  state_d   = DONE;
                  alarm_d   = (ALARM_CYC != 0);
                  alm_tmr_d = ALM_W'(ALARM_CYC);
`ifdef CUENTA_BLINK_EN
                  blk_d     = '0;
`endif
               end else if (bus.start_stop) begin
                  state_d = PAUSE;
               end
            end

            PAUSE: begin
               if (bus.start_stop) state_d = RUN;
            end

            DONE: begin
               seg_d = '0;
               min_d = '0;
               if (bus.start_stop) begin
                  state_d   = IDLE;
                  seg_d     = pre_seg_c;
                  min_d     = pre_min_c;
                  alm_tmr_d = '0;
               end else if (alm_tmr_q != '0) begin
                  alm_tmr_d = alm_tmr_q - ALM_W'(1);
`ifdef CUENTA_BLINK_EN
                  if (blk_q == BL_W'(HALF - 1)) begin
                     blk_d   = '0;
                     alarm_d = ~alarm_q;
                  end else begin
                     blk_d   = blk_q + BL_W'(1);
                     alarm_d = alarm_q;
                  end
                  if (alm_tmr_q == ALM_W'(1)) alarm_d = 1'b0;
`else
                  alarm_d = (alm_tmr_q != ALM_W'(1));
`endif
               end
            end

            default: state_d = IDLE;
         endcase
      end

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         seg_q     <= '0;
         min_q     <= '0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
         tick_q    <= 1'b0;
         alm_tmr_q <= '0;
`ifdef CUENTA_BLINK_EN
         blk_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         min_q     <= min_d;
         running_q <= running_d;
         alarm_q   <= alarm_d;
         tick_q    <= tick_c;
         alm_tmr_q <= alm_tmr_d;
`ifdef CUENTA_BLINK_EN
         blk_q     <= blk_d;
`endif
      end
   end

   assign bus.seg     = seg_q;
   assign bus.min     = min_q;
   assign bus.running = running_q;
   assign bus.alarm   = alarm_q;
   assign bus.tick    = tick_q;

endmodule

// File: tb/tb_cuenta_regresiva.sv
// -----------------------------------------------------------------------------
// tb_cuenta_regresiva: scoreboard bench for the countdown timer
// (CLK_HZ=10, ALARM_SEC=2). Expected output snapshots are queued with the
// cycle they are due and compared on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_cuenta_regresiva;

   localparam int unsigned CLK_HZ    = 10;
   localparam int unsigned ALARM_SEC = 2;

   typedef struct {
      int unsigned due;
      int unsigned id;
      logic [5:0]  seg;
      logic [5:0]  min;
      logic        running;
      logic        alarm;
      logic        tick;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned n_id = 0;
   exp_t        sb[$];

   cuenta_regresiva_if bus ();

   cuenta_regresiva #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sb_push(input int unsigned due, input logic [5:0] m, input logic [5:0] s,
                          input logic r, input logic a, input logic t);
      exp_t e;
      e.due = due; e.id = n_id; e.min = m; e.seg = s;
      e.running = r; e.alarm = a; e.tick = t;
      n_id++;
      sb.push_back(e);
   endtask

   // Compare every expectation due in this cycle against the DUT outputs.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            check($sformatf("e%0d_seg", sb[i].id),     32'(bus.seg),     32'(sb[i].seg));
            check($sformatf("e%0d_min", sb[i].id),     32'(bus.min),     32'(sb[i].min));
            check($sformatf("e%0d_running", sb[i].id), 32'(bus.running), 32'(sb[i].running));
            check($sformatf("e%0d_alarm", sb[i].id),   32'(bus.alarm),   32'(sb[i].alarm));
            check($sformatf("e%0d_tick", sb[i].id),    32'(bus.tick),    32'(sb[i].tick));
            sb.delete(i);
         end
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int unsigned k);
      while (cyc < k) step(1);
   endtask

   task automatic set_preset(input logic [5:0] m, input logic [5:0] s);
      bus.setMin = m;
      bus.setSeg = s;
   endtask

   // One-cycle start_stop pulse; returns just after the edge that sampled it.
   task automatic press();
      bus.start_stop = 1'b1;
      step(1);
      bus.start_stop = 1'b0;
   endtask

   task automatic edit_pulse(input logic [5:0] m, input logic [5:0] s, input logic ss);
      set_preset(m, s);
      bus.setTime    = 1'b1;
      bus.start_stop = ss;
      step(1);
      bus.setTime    = 1'b0;
      bus.start_stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=%0d exp=0", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned s, r, t;
      rst            = 1'b1;
      bus.setTime    = 1'b0;
      bus.setSeg     = '0;
      bus.setMin     = '0;
      bus.start_stop = 1'b0;

      // Reset state.
      step(2);
      sb_push(cyc, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // 00:03 countdown to alarm window.
      set_preset(0, 3);
      step(2);
      sb_push(cyc, 0, 3, 0, 0, 0);
      press();
      s = cyc;
      sb_push(s + 9,  0, 3, 1, 0, 0);
      sb_push(s + 10, 0, 2, 1, 0, 1);
      sb_push(s + 11, 0, 2, 1, 0, 0);
      sb_push(s + 20, 0, 1, 1, 0, 1);
      sb_push(s + 30, 0, 0, 0, 1, 1);
      sb_push(s + 31, 0, 0, 0, 1, 0);
`ifdef CUENTA_BLINK_EN
      sb_push(s + 35, 0, 0, 0, 0, 0);
      sb_push(s + 40, 0, 0, 0, 1, 0);
      sb_push(s + 49, 0, 0, 0, 0, 0);
`else
      sb_push(s + 35, 0, 0, 0, 1, 0);
      sb_push(s + 49, 0, 0, 0, 1, 0);
`endif
      sb_push(s + 50, 0, 0, 0, 0, 0);
      sb_push(s + 52, 0, 0, 0, 0, 0);
      wait_cyc(s + 52);

      // Acknowledge from DONE reloads the preset.
      set_preset(1, 0);
      press();
      sb_push(cyc, 1, 0, 0, 0, 0);

      // 01:00 borrow, then edit mode mid-RUN with saturating preset.
      step(2);
      press();
      s = cyc;
      sb_push(s + 10, 0, 59, 1, 0, 1);
      sb_push(s + 11, 0, 59, 1, 0, 0);
      wait_cyc(s + 13);
      edit_pulse(7, 62, 1'b1);
      t = cyc;
      sb_push(t,     7, 59, 0, 0, 0);
      sb_push(t + 5, 7, 59, 0, 0, 0);
      wait_cyc(t + 5);

      // 00:05 pause at cycle 15, hold 100 cycles, resume.
      set_preset(0, 5);
      step(2);
      press();
      s = cyc;
      sb_push(s + 10,  0, 4, 1, 0, 1);
      sb_push(s + 15,  0, 4, 0, 0, 0);
      sb_push(s + 60,  0, 4, 0, 0, 0);
      sb_push(s + 115, 0, 4, 0, 0, 0);
      wait_cyc(s + 14);
      press();
      wait_cyc(s + 115);
      press();
      r = cyc;
      sb_push(r + 4, 0, 4, 1, 0, 0);
      sb_push(r + 5, 0, 3, 1, 0, 1);
      wait_cyc(r + 6);
      edit_pulse(0, 0, 1'b0);
      sb_push(cyc, 0, 0, 0, 0, 0);

      // 00:00 start is refused; no tick appears.
      step(2);
      press();
      s = cyc;
      for (int k = 0; k < 30; k++) sb_push(s + k, 0, 0, 0, 0, 0);
      wait_cyc(s + 31);

      step(2);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
